// File: rtl/event_readout_sequencer.sv
// Event readout sequencer: joins a header and NCHAN completion streams, issues a datamover
// command plus fragment control word per event, then waits for status. Optional: EVENT_READOUT_SEQ_TIMEOUT_EN.
module event_readout_sequencer #(
  parameter int unsigned NCHAN          = 4,
  parameter int unsigned CMPL_WIDTH     = 64,
  parameter int unsigned CMPL_ERR_BITS  = 32,
  parameter int unsigned ADDR_BITS      = 13,
  parameter int unsigned OFFSET_BITS    = 19,
  parameter logic [OFFSET_BITS-1:0] START_OFFSET = 19'h03E00,
  parameter logic [18:0] BTT            = 19'd459008,
  parameter int unsigned TIMEOUT_CYCLES = 2**20
) (
  input  logic                        memclk,
  input  logic                        aresetn,
  input  logic [23:0]                 s_hdr_tdata,
  input  logic                        s_hdr_tvalid,
  output logic                        s_hdr_tready,
  input  logic [NCHAN*CMPL_WIDTH-1:0] s_cmpl_tdata,
  input  logic [NCHAN-1:0]            s_cmpl_tvalid,
  output logic [NCHAN-1:0]            s_cmpl_tready,
  input  logic [NCHAN-1:0]            chan_mask,
  output logic [71:0]                 m_cmd_tdata,
  output logic                        m_cmd_tvalid,
  input  logic                        m_cmd_tready,
  input  logic [7:0]                  s_sts_tdata,
  input  logic                        s_sts_tvalid,
  output logic                        s_sts_tready,
  output logic [31:0]                 m_ctrl_tdata,
  output logic                        m_ctrl_tvalid,
  input  logic                        m_ctrl_tready,
  input  logic                        clear_err,
  output logic [NCHAN+2:0]            err_o,
  output logic [31:0]                 event_count,
  output logic                        busy
);

  localparam int unsigned ERR_W = NCHAN + 3;

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT_STS = 2'd2} state_t;

  state_t                 state_q, state_d;
  logic [ADDR_BITS-1:0]   upper_addr_q, upper_addr_d;
  logic                   cmd_valid_q, cmd_valid_d;
  logic                   ctrl_valid_q, ctrl_valid_d;
  logic [31:0]            event_count_q, event_count_d;
  logic [NCHAN-1:0]       ch_err_q, ch_err_d;
  logic                   hdr_err_q, hdr_err_d;
  logic                   sts_err_q, sts_err_d;
  logic                   tmo_err_q, tmo_err_d;
  logic [ERR_W-1:0]       err_q, err_d;
  logic                   ready;
  logic                   unused_ok;
`ifdef EVENT_READOUT_SEQ_TIMEOUT_EN
  logic [31:0]            tmo_cnt_q, tmo_cnt_d;
`endif

  assign ready = s_hdr_tvalid && (&(s_cmpl_tvalid | chan_mask));

  always_ff @(posedge memclk) begin
    if (!aresetn) begin
      state_q       <= IDLE;
      upper_addr_q  <= '0;
      cmd_valid_q   <= 1'b0;
      ctrl_valid_q  <= 1'b0;
      event_count_q <= '0;
      ch_err_q      <= '0;
      hdr_err_q     <= 1'b0;
      sts_err_q     <= 1'b0;
      tmo_err_q     <= 1'b0;
      err_q         <= '0;
    end else begin
      state_q       <= state_d;
      upper_addr_q  <= upper_addr_d;
      cmd_valid_q   <= cmd_valid_d;
      ctrl_valid_q  <= ctrl_valid_d;
      event_count_q <= event_count_d;
      ch_err_q      <= ch_err_d;
      hdr_err_q     <= hdr_err_d;
      sts_err_q     <= sts_err_d;
      tmo_err_q     <= tmo_err_d;
      err_q         <= err_d;
    end
  end

`ifdef EVENT_READOUT_SEQ_TIMEOUT_EN
  // Status watchdog counter
  always_ff @(posedge memclk) begin
    if (!aresetn) tmo_cnt_q <= '0;
    else          tmo_cnt_q <= tmo_cnt_d;
  end
`endif

  // Next-state, stream handshakes and one-cycle error pulses
  always_comb begin
    state_d       = state_q;
    upper_addr_d  = upper_addr_q;
    cmd_valid_d   = cmd_valid_q;
    ctrl_valid_d  = ctrl_valid_q;
    event_count_d = event_count_q;
    ch_err_d      = '0;
    hdr_err_d     = 1'b0;
    sts_err_d     = 1'b0;
    tmo_err_d     = 1'b0;
    s_hdr_tready  = 1'b0;
    s_cmpl_tready = '0;
    s_sts_tready  = 1'b0;
`ifdef EVENT_READOUT_SEQ_TIMEOUT_EN
    tmo_cnt_d     = '0;
`endif
    unique case (state_q)
      IDLE: begin
`ifdef EVENT_READOUT_SEQ_TIMEOUT_EN
        s_sts_tready = aresetn;
`endif
        if (ready && aresetn) begin
          s_hdr_tready  = 1'b1;
          s_cmpl_tready = ~chan_mask;
          upper_addr_d  = s_hdr_tdata[8 +: ADDR_BITS];
          cmd_valid_d   = 1'b1;
          ctrl_valid_d  = 1'b1;
          hdr_err_d     = |s_hdr_tdata[7:0];
          for (int unsigned i = 0; i < NCHAN; i++) begin
            ch_err_d[i] = !chan_mask[i] && (|s_cmpl_tdata[i*CMPL_WIDTH +: CMPL_ERR_BITS]);
          end
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cmd_valid_d  = cmd_valid_q && !m_cmd_tready;
        ctrl_valid_d = ctrl_valid_q && !m_ctrl_tready;
        if (!cmd_valid_d && !ctrl_valid_d) state_d = WAIT_STS;
      end
      WAIT_STS: begin
        s_sts_tready = aresetn;
        if (s_sts_tvalid && aresetn) begin
          event_count_d = event_count_q + 32'd1;
          sts_err_d     = !s_sts_tdata[7] || (|s_sts_tdata[6:4]);
          state_d       = IDLE;
        end
`ifdef EVENT_READOUT_SEQ_TIMEOUT_EN
        else if (tmo_cnt_q == 32'(TIMEOUT_CYCLES - 1)) begin
          tmo_err_d = 1'b1;
          state_d   = IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 32'd1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
    // Set beats clear when both land together
    err_d = clear_err ? '0 : err_q;
    err_d = err_d | {tmo_err_q, sts_err_q, hdr_err_q, ch_err_q};
  end

  assign m_cmd_tvalid  = cmd_valid_q;
  assign m_ctrl_tvalid = ctrl_valid_q;
  assign m_cmd_tdata   = cmd_valid_q
                       ? {8'h00, upper_addr_q, START_OFFSET, 13'b0_1_000000_1_0000, BTT} : '0;
  // Address MSB intentionally dropped from the fragment control word
  assign m_ctrl_tdata  = ctrl_valid_q ? {upper_addr_q[ADDR_BITS-2:0], 1'b0, BTT} : '0;
  assign err_o         = err_q;
  assign event_count   = event_count_q;
  assign busy          = (state_q != IDLE);

`ifdef EVENT_READOUT_SEQ_TIMEOUT_EN
  assign unused_ok = ^{s_cmpl_tdata, s_hdr_tdata, s_sts_tdata[3:0]};
`else
  assign unused_ok = ^{s_cmpl_tdata, s_hdr_tdata, s_sts_tdata[3:0], 32'(TIMEOUT_CYCLES)};
`endif

endmodule

// File: tb/tb_event_readout_sequencer.sv
// Bench for event_readout_sequencer: directed scenarios with literal expectations, then a
// randomized run compared every cycle against an event-level reference model.
`timescale 1ns/1ps
module tb_event_readout_sequencer;
  localparam int unsigned NCHAN = 4;
  localparam int unsigned CW    = 64;
  localparam int unsigned EW    = NCHAN + 3;
  localparam int unsigned BTT_V = 459008;

  logic                  memclk = 1'b0;
  logic                  aresetn;
  logic [23:0]           s_hdr_tdata;
  logic                  s_hdr_tvalid, s_hdr_tready;
  logic [NCHAN*CW-1:0]   s_cmpl_tdata;
  logic [NCHAN-1:0]      s_cmpl_tvalid, s_cmpl_tready, chan_mask;
  logic [71:0]           m_cmd_tdata;
  logic                  m_cmd_tvalid, m_cmd_tready;
  logic [7:0]            s_sts_tdata;
  logic                  s_sts_tvalid, s_sts_tready;
  logic [31:0]           m_ctrl_tdata;
  logic                  m_ctrl_tvalid, m_ctrl_tready;
  logic                  clear_err;
  logic [EW-1:0]         err_o;
  logic [31:0]           event_count;
  logic                  busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 memclk = ~memclk;

  event_readout_sequencer dut (
    .memclk(memclk), .aresetn(aresetn),
    .s_hdr_tdata(s_hdr_tdata), .s_hdr_tvalid(s_hdr_tvalid), .s_hdr_tready(s_hdr_tready),
    .s_cmpl_tdata(s_cmpl_tdata), .s_cmpl_tvalid(s_cmpl_tvalid), .s_cmpl_tready(s_cmpl_tready),
    .chan_mask(chan_mask),
    .m_cmd_tdata(m_cmd_tdata), .m_cmd_tvalid(m_cmd_tvalid), .m_cmd_tready(m_cmd_tready),
    .s_sts_tdata(s_sts_tdata), .s_sts_tvalid(s_sts_tvalid), .s_sts_tready(s_sts_tready),
    .m_ctrl_tdata(m_ctrl_tdata), .m_ctrl_tvalid(m_ctrl_tvalid), .m_ctrl_tready(m_ctrl_tready),
    .clear_err(clear_err), .err_o(err_o), .event_count(event_count), .busy(busy)
  );

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Command word from the address: upper bits shifted above the 19-bit offset, flags + BTT below
  function automatic logic [71:0] exp_cmd(input int unsigned addr);
    logic [31:0] a32, lo32;
    a32  = 32'((addr << 19) + 32'h3E00);
    lo32 = 32'((32'd1 << 30) + (32'd1 << 23) + BTT_V);
    return {8'h00, a32, lo32};
  endfunction

  function automatic logic [31:0] exp_ctrl(input int unsigned addr);
    return 32'(((addr % 4096) << 20) + BTT_V);
  endfunction

  // Reference model: which event phase is outstanding, and the error-set latency
  bit              m_issue, m_cmd_pend, m_ctrl_pend, m_wait;
  int unsigned     m_addr, m_count;
  bit [EW-1:0]     m_err, m_stage;

  initial begin : compare
    bit rdy, e_hdr, e_sts;
    bit [NCHAN-1:0] e_cmpl;
    bit n_issue, n_cmd, n_ctrl, n_wait;
    int unsigned n_addr, n_count;
    bit [EW-1:0] n_err, n_stage, setv;
    logic [CW-1:0] w;
    m_issue = 0; m_cmd_pend = 0; m_ctrl_pend = 0; m_wait = 0;
    m_addr = 0; m_count = 0; m_err = '0; m_stage = '0;
    @(posedge memclk);
    forever begin
      @(negedge memclk);
      rdy    = s_hdr_tvalid && ((s_cmpl_tvalid | chan_mask) == '1);
      e_hdr  = aresetn && !m_issue && !m_wait && rdy;
      e_cmpl = e_hdr ? ~chan_mask : '0;
      e_sts  = aresetn && m_wait;
      chk("hdr_tready", s_hdr_tready, e_hdr);
      chk("cmpl_tready", s_cmpl_tready, e_cmpl);
      chk("sts_tready", s_sts_tready, e_sts);
      chk("cmd_tvalid", m_cmd_tvalid, m_cmd_pend);
      chk("ctrl_tvalid", m_ctrl_tvalid, m_ctrl_pend);
      chk("cmd_tdata", m_cmd_tdata, m_cmd_pend ? exp_cmd(m_addr) : 72'd0);
      chk("ctrl_tdata", m_ctrl_tdata, m_ctrl_pend ? exp_ctrl(m_addr) : 32'd0);
      chk("busy", busy, m_issue || m_wait);
      chk("err_o", err_o, m_err);
      chk("event_count", event_count, m_count);

      setv = '0;
      n_issue = m_issue; n_cmd = m_cmd_pend; n_ctrl = m_ctrl_pend; n_wait = m_wait;
      n_addr = m_addr; n_count = m_count;
      if (e_hdr) begin
        n_addr  = (s_hdr_tdata >> 8) % 8192;
        n_issue = 1; n_cmd = 1; n_ctrl = 1;
        setv[NCHAN] = (s_hdr_tdata[7:0] != 8'd0);
        for (int i = 0; i < NCHAN; i++) begin
          w = s_cmpl_tdata[i*CW +: CW];
          setv[i] = !chan_mask[i] && (w[31:0] != 32'd0);
        end
      end else if (m_issue) begin
        if (m_cmd_tready)  n_cmd  = 0;
        if (m_ctrl_tready) n_ctrl = 0;
        if (!n_cmd && !n_ctrl) begin n_issue = 0; n_wait = 1; end
      end else if (m_wait && s_sts_tvalid) begin
        n_wait  = 0;
        n_count = m_count + 1;
        setv[NCHAN+1] = !s_sts_tdata[7] || (s_sts_tdata[6:4] != 3'd0);
      end
      n_err   = (clear_err ? '0 : m_err) | m_stage;
      n_stage = setv;
      if (!aresetn) begin
        n_issue = 0; n_cmd = 0; n_ctrl = 0; n_wait = 0;
        n_addr = 0; n_count = 0; n_err = '0; n_stage = '0;
      end
      @(posedge memclk);
      m_issue = n_issue; m_cmd_pend = n_cmd; m_ctrl_pend = n_ctrl; m_wait = n_wait;
      m_addr = n_addr; m_count = n_count; m_err = n_err; m_stage = n_stage;
    end
  end

  task automatic tick();
    @(posedge memclk);
    #1;
  endtask

  task automatic drop_streams();
    s_hdr_tvalid  = 1'b0;
    s_cmpl_tvalid = '0;
  endtask

  task automatic wait_idle(input string name);
    bit done;
    done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge memclk);
      if (busy === 1'b0) done = 1;
    end
    chk(name, busy, 1'b0);
    tick();
  endtask

  initial begin : stim
    aresetn = 1'b0; clear_err = 1'b0; chan_mask = '0;
    s_hdr_tdata = '0; s_hdr_tvalid = 1'b0; s_cmpl_tdata = '0; s_cmpl_tvalid = '0;
    m_cmd_tready = 1'b0; m_ctrl_tready = 1'b0; s_sts_tdata = '0; s_sts_tvalid = 1'b0;
    repeat (2) tick();
    @(negedge memclk);
    chk("rst_count", event_count, 0);
    chk("rst_err", err_o, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cmd_tvalid", m_cmd_tvalid, 0);
    tick();
    aresetn = 1'b1;

    // Basic event with literal command/control words
    m_cmd_tready = 1'b1; m_ctrl_tready = 1'b1; s_sts_tvalid = 1'b1; s_sts_tdata = 8'h80;
    s_hdr_tdata = 24'h001200; s_hdr_tvalid = 1'b1; s_cmpl_tvalid = 4'hF;
    @(negedge memclk);
    chk("t1_hdr_tready", s_hdr_tready, 1);
    chk("t1_cmpl_tready", s_cmpl_tready, 4'hF);
    tick(); drop_streams();
    @(negedge memclk);
    chk("t1_cmd_tdata", m_cmd_tdata, 72'h00_0090_3E00_4087_0100);
    chk("t1_ctrl_tdata", m_ctrl_tdata, 32'h0127_0100);
    wait_idle("t1_done");
    chk("t1_count", event_count, 1);
    tick();
    chk("t1_err", err_o, 0);

    // Masked channel proceeds without its valid; unmasking stalls
    chan_mask = 4'b0100; s_hdr_tdata = 24'h000300; s_hdr_tvalid = 1'b1; s_cmpl_tvalid = 4'b1011;
    @(negedge memclk);
    chk("t2_cmpl_tready", s_cmpl_tready, 4'b1011);
    tick(); drop_streams();
    wait_idle("t2_done");
    chk("t2_count", event_count, 2);
    chan_mask = 4'b0000; s_hdr_tvalid = 1'b1; s_cmpl_tvalid = 4'b1011;
    repeat (5) tick();
    chk("t2_stall_busy", busy, 0);
    chk("t2_stall_hdr_tready", s_hdr_tready, 0);
    chk("t2_stall_count", event_count, 2);
    drop_streams();

    // Control accept held off 10 cycles while command goes first
    m_ctrl_tready = 1'b0; s_hdr_tdata = 24'h00A500; s_hdr_tvalid = 1'b1; s_cmpl_tvalid = 4'hF;
    tick(); drop_streams();
    @(negedge memclk);
    chk("t3_cmd_v_first", m_cmd_tvalid, 1);
    chk("t3_ctrl_v_first", m_ctrl_tvalid, 1);
    tick();
    chk("t3_cmd_v_drop", m_cmd_tvalid, 0);
    chk("t3_ctrl_v_hold", m_ctrl_tvalid, 1);
    repeat (8) tick();
    chk("t3_sts_rdy_stall", s_sts_tready, 0);
    tick();
    m_ctrl_tready = 1'b1;
    chk("t3_still_issue", s_sts_tready, 0);
    tick();
    chk("t3_wait_sts", s_sts_tready, 1);
    chk("t3_ctrl_v_drop", m_ctrl_tvalid, 0);
    wait_idle("t3_done");
    chk("t3_count", event_count, 3);

    // Error sources: ch1, header byte, status
    s_hdr_tdata = 24'h000004; s_cmpl_tdata[1*CW +: CW] = 64'h1; s_sts_tdata = 8'h40;
    s_hdr_tvalid = 1'b1; s_cmpl_tvalid = 4'hF;
    tick(); drop_streams(); s_cmpl_tdata = '0;
    wait_idle("t4_done");
    tick();
    chk("t4_err", err_o, 7'b0110010);
    chk("t4_count", event_count, 4);
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0; s_sts_tdata = 8'h80;
    chk("t4_clear", err_o, 0);

    // Reset while command/control are outstanding
    m_cmd_tready = 1'b0; m_ctrl_tready = 1'b0;
    s_hdr_tdata = 24'h000700; s_hdr_tvalid = 1'b1; s_cmpl_tvalid = 4'hF;
    tick(); drop_streams();
    chk("t5_in_issue", busy, 1);
    aresetn = 1'b0;
    tick();
    aresetn = 1'b1;
    chk("t5_cmd_v", m_cmd_tvalid, 0);
    chk("t5_ctrl_v", m_ctrl_tvalid, 0);
    chk("t5_busy", busy, 0);
    chk("t5_count", event_count, 0);

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      s_hdr_tvalid = ($urandom_range(3) == 0);
      s_hdr_tdata  = 24'($urandom);
      if ($urandom_range(3) != 0) s_hdr_tdata[7:0] = 8'h00;
      for (int i = 0; i < NCHAN; i++) begin
        s_cmpl_tvalid[i] = ($urandom_range(3) != 0);
        s_cmpl_tdata[i*CW +: CW] = {$urandom, ($urandom_range(7) == 0) ? $urandom : 32'd0};
      end
      if ($urandom_range(15) == 0) chan_mask = 4'($urandom);
      m_cmd_tready  = 1'($urandom_range(1));
      m_ctrl_tready = 1'($urandom_range(1));
      s_sts_tvalid  = ($urandom_range(2) == 0);
      s_sts_tdata   = ($urandom_range(3) == 0) ? 8'($urandom) : 8'h80;
      clear_err     = ($urandom_range(31) == 0);
      aresetn       = ($urandom_range(399) != 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
